// File: rtl/clk_div_gen_pkg.sv
// Shared constants and divisor sanitising for the clock-enable generator.
package clk_div_pkg;

   localparam int unsigned DEF_DIV  = 2;
   localparam int unsigned DEF_HIGH = 1;

   // Divisors below 2 cannot form a period with both a tick and a low phase.
   function automatic int unsigned clamp_div(input int unsigned d);
      return (d < 2) ? 2 : d;
   endfunction

endpackage

// File: rtl/clk_div_gen_if.sv
// Settings write bus: one write per cycle, throttled by the target channel's pending flag.
interface clk_div_gen_if #(
   parameter int NCH = 4,
   parameter int W   = 16
);
   localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

   logic          wr_en;
   logic [CW-1:0] wr_chan;
   logic [W-1:0]  wr_div;
   logic [W-1:0]  wr_high;
   logic          wr_ready;

   modport master (output wr_en, output wr_chan, output wr_div, output wr_high, input wr_ready);
   modport slave  (input wr_en, input wr_chan, input wr_div, input wr_high, output wr_ready);
endinterface

// File: rtl/clk_div_gen_chan.sv
// One divider channel: period counter, active/shadow settings, registered outputs.
module clk_div_chan
   import clk_div_pkg::*;
#(
   parameter int          W            = 16,
   parameter int unsigned DEFAULT_DIV  = DEF_DIV,
   parameter int unsigned DEFAULT_HIGH = DEF_HIGH
) (
   input  logic         clkin,
   input  logic         reset,
   input  logic         en,
   input  logic         wr_acc,
   input  logic [W-1:0] wr_div,
   input  logic [W-1:0] wr_high,
   output logic         clkout,
   output logic         tick,
   output logic         lock,
   output logic         pending
);

   logic [W-1:0] cnt, div_act, high_act, div_sh, high_sh;
   logic [W-1:0] cnt_n, div_act_n, high_act_n, div_sh_n, high_sh_n;
   logic         pend_n, lock_n, wrap;

   always_comb begin
      cnt_n      = cnt;
      div_act_n  = div_act;
      high_act_n = high_act;
      div_sh_n   = div_sh;
      high_sh_n  = high_sh;
      pend_n     = pending;
      lock_n     = lock;
      wrap       = en && (cnt == div_act - 1'b1);

      // Parking at div-1 while disabled makes the first enabled edge a wrap.
      if (!en) begin
         cnt_n  = div_act - 1'b1;
         lock_n = 1'b0;
      end else if (wrap) begin
         cnt_n = '0;
         if (pending) begin
            div_act_n  = div_sh;
            high_act_n = high_sh;
            pend_n     = 1'b0;
         end
         lock_n = 1'b1;
      end else begin
         cnt_n = cnt + 1'b1;
      end

      // A write is only accepted with pending clear, so it never races the apply above.
      if (wr_acc) begin
         div_sh_n  = W'(clamp_div(32'(wr_div)));
         high_sh_n = wr_high;
         pend_n    = 1'b1;
         lock_n    = 1'b0;
      end
   end

   always_ff @(posedge clkin) begin
      if (reset) begin
         cnt      <= '0;
         div_act  <= W'(DEFAULT_DIV);
         high_act <= W'(DEFAULT_HIGH);
         div_sh   <= W'(DEFAULT_DIV);
         high_sh  <= W'(DEFAULT_HIGH);
         pending  <= 1'b0;
         lock     <= 1'b0;
         clkout   <= 1'b0;
         tick     <= 1'b0;
      end else begin
         cnt      <= cnt_n;
         div_act  <= div_act_n;
         high_act <= high_act_n;
         div_sh   <= div_sh_n;
         high_sh  <= high_sh_n;
         pending  <= pend_n;
         lock     <= lock_n;
         clkout   <= en && (cnt_n < high_act_n);
         tick     <= en && (cnt_n == '0);
      end
   end

endmodule

// File: rtl/clk_div_gen.sv
// Multi-channel clock-enable generator: write decode and ready muxing around NCH channels.
module clk_div_gen
   import clk_div_pkg::*;
#(
   parameter int          NCH          = 4,
   parameter int          W            = 16,
   parameter int unsigned DEFAULT_DIV  = DEF_DIV,
   parameter int unsigned DEFAULT_HIGH = DEF_HIGH
) (
   input  logic           clkin,
   input  logic           reset,
   input  logic [NCH-1:0] ch_en,
   clk_div_gen_if.slave   wr,
   output logic [NCH-1:0] clkout,
   output logic [NCH-1:0] tick,
   output logic [NCH-1:0] lock,
   output logic [NCH-1:0] pending
);

   localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

   always_comb begin
      wr.wr_ready = 1'b1;
      if (int'(wr.wr_chan) < NCH) wr.wr_ready = ~pending[wr.wr_chan];
   end

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      logic acc;
      assign acc = wr.wr_en && wr.wr_ready && (wr.wr_chan == CW'(i));

      clk_div_chan #(
         .W            (W),
         .DEFAULT_DIV  (DEFAULT_DIV),
         .DEFAULT_HIGH (DEFAULT_HIGH)
      ) u_chan (
         .clkin   (clkin),
         .reset   (reset),
         .en      (ch_en[i]),
         .wr_acc  (acc),
         .wr_div  (wr.wr_div),
         .wr_high (wr.wr_high),
         .clkout  (clkout[i]),
         .tick    (tick[i]),
         .lock    (lock[i]),
         .pending (pending[i])
      );
   end

endmodule
